spi_target_mux: RTL

- Parametrised SPI storage switch between the core's single SPI master (SD interface) and NUM_TGT targets.
- Target 0 is the physical SD card; targets 1..NUM_TGT-1 are virtual sd_card instances backed by mounted images.
- Retargets only on image mount, and only when the bus is provably idle, so an in-flight transfer is never split across cards.
- Provides a saturating activity timer for the disk LED and an explicit switch-pending status.

---
 rtl/spi_mux_pkg.sv | 21 ++
 rtl/spi_activity_timer.sv | 52 +++++
 rtl/spi_target_mux.sv | 130 +++++++++++++
 3 files changed

// File: rtl/spi_mux_pkg.sv
// Shared types and helpers for the SPI storage target switch.
// Holds the switch FSM encoding and the mount-request decode.
package spi_mux_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PEND,
        ST_GUARD
    } state_t;

    localparam int PHYS_TGT = 0;

    // Anything that is not a populated virtual slot falls back to the physical card.
    function automatic int decode_target(input int idx, input logic size_nz, input int num_tgt);
        if (size_nz && (idx >= 1) && (idx < num_tgt)) begin
            return idx;
        end
        return PHYS_TGT;
    endfunction

endpackage

// File: rtl/spi_activity_timer.sv
// Disk-LED activity timer: edge detect on the routed SPI lines feeding a
// saturating idle counter; activity stays high until TIMEOUT quiet cycles.
module spi_activity_timer
    import spi_mux_pkg::*;
#(
    parameter int TIMEOUT = 1000000,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic sck,
    input  logic mosi,
    input  logic miso,
    output logic activity
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [2:0]       prev;
    logic [2:0]       cur;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cur     = {sck, mosi, miso};
        cnt_nxt = cnt;
        if (armed) begin
            if (cur != prev) begin
                cnt_nxt = '0;
            end else if (cnt != CNT_MAX) begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // The first cycle out of reset only captures prev, so stale reset values never count as a toggle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            prev     <= '0;
            armed    <= 1'b0;
            cnt      <= CNT_MAX;
            activity <= 1'b0;
        end else begin
            prev     <= cur;
            armed    <= 1'b1;
            cnt      <= cnt_nxt;
            activity <= (cnt_nxt != CNT_MAX);
        end
    end

endmodule

// File: rtl/spi_target_mux.sv
// SPI storage switch: routes the core SPI master to one of NUM_TGT targets and
// retargets on image mount only after host_ss has been idle for GUARD_CYC cycles.
//
// state    | meaning
// ST_RUN   | routing to sel, no retarget outstanding
// ST_PEND  | retarget to req requested, waiting for host_ss high
// ST_GUARD | host_ss high, counting idle cycles before committing req
module spi_target_mux
    import spi_mux_pkg::*;
#(
    parameter  int NUM_TGT   = 2,
    parameter  int GUARD_CYC = 4,
    parameter  int TIMEOUT   = 1000000,
    localparam int IDX_W     = (NUM_TGT > 2) ? $clog2(NUM_TGT) : 1,
    localparam int CNT_W     = $clog2(TIMEOUT + 1)
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               mount_stb,
    input  logic [IDX_W-1:0]   mount_idx,
    input  logic               mount_size_nz,
    input  logic               host_sck,
    input  logic               host_mosi,
    input  logic               host_ss,
    output logic               host_miso,
    output logic [NUM_TGT-1:0] tgt_sck,
    output logic [NUM_TGT-1:0] tgt_mosi,
    output logic [NUM_TGT-1:0] tgt_ss,
    input  logic [NUM_TGT-1:0] tgt_miso,
    output logic [IDX_W-1:0]   sel,
    output logic               switch_pending,
    output logic               activity
);

    localparam int GCNT_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC + 1) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  req;
    logic [IDX_W-1:0]  req_nxt;
    logic [IDX_W-1:0]  sel_nxt;
    logic [IDX_W-1:0]  tgt_dec;
    logic [GCNT_W-1:0] gcnt;
    logic [GCNT_W-1:0] gcnt_nxt;

    always_comb begin
        tgt_ss          = '1;
        tgt_sck         = '0;
        tgt_mosi        = '0;
        tgt_ss[sel]     = host_ss;
        tgt_sck[sel]    = host_sck;
        tgt_mosi[sel]   = host_mosi;
    end

    assign host_miso      = tgt_miso[sel];
    assign switch_pending = (state != ST_RUN);

    always_comb begin
        state_nxt = state;
        req_nxt   = req;
        sel_nxt   = sel;
        gcnt_nxt  = gcnt;
        tgt_dec   = IDX_W'(decode_target(int'(mount_idx), mount_size_nz, NUM_TGT));

        case (state)
            ST_RUN: begin
                if (mount_stb && (tgt_dec != sel)) begin
                    req_nxt   = tgt_dec;
                    state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (host_ss) begin
                    gcnt_nxt  = GCNT_W'(1);
                    state_nxt = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (!host_ss) begin
                    state_nxt = ST_PEND;
                end else if (gcnt == GCNT_W'(GUARD_CYC)) begin
                    sel_nxt   = req;
                    state_nxt = ST_RUN;
                end else begin
                    gcnt_nxt = gcnt + 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        // A new mount while pending wins over a same-cycle commit and restarts the guard.
        if ((state != ST_RUN) && mount_stb) begin
            sel_nxt  = sel;
            gcnt_nxt = '0;
            if (tgt_dec == sel) begin
                state_nxt = ST_RUN;
            end else begin
                req_nxt   = tgt_dec;
                state_nxt = ST_PEND;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= ST_RUN;
            req   <= '0;
            sel   <= IDX_W'(PHYS_TGT);
            gcnt  <= '0;
        end else begin
            state <= state_nxt;
            req   <= req_nxt;
            sel   <= sel_nxt;
            gcnt  <= gcnt_nxt;
        end
    end

    spi_activity_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_activity (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .sck      (host_sck),
        .mosi     (host_mosi),
        .miso     (host_miso),
        .activity (activity)
    );

endmodule
